// File: rtl/mem_stage_sram.sv
// Memory pipeline stage that serialises 32-bit loads and stores into two
// 16-bit accesses on an external asynchronous SRAM, freezing the pipe meanwhile.
module mem_stage_sram (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] val_Rm_in,
  input  logic [3:0]  dst_in,
  output logic        WB_en_out,
  output logic        mem_read_out,
  output logic [3:0]  dst_out,
  output logic [31:0] alu_out_out,
  output logic [31:0] mem_data_out,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  logic [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t      state, state_n;
  logic [16:0] word;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign WB_en_out    = WB_en_in;
  assign mem_read_out = mem_read_in;
  assign dst_out      = dst_in;
  assign alu_out_out  = alu_out_in;

  // (alu_out_in - 1024)[18:2]; 1024 is word aligned so no borrow reaches bit 2
  assign word = alu_out_in[18:2] - 17'd256;

  assign SRAM_DQ = dq_oe ? dq_out : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_data_out <= '0;
    end else begin
      state <= state_n;
      if (state == RD_LO) mem_data_out[15:0]  <= SRAM_DQ;
      if (state == RD_HI) mem_data_out[31:16] <= SRAM_DQ;
    end
  end

  always_comb begin
    state_n   = state;
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_write_in)     state_n = WR_LO;
        else if (mem_read_in) state_n = RD_LO;
        else                  ready   = 1'b1;
      end
      RD_LO: begin
        SRAM_ADDR = {word, 1'b0};
        state_n   = RD_HI;
      end
      RD_HI: begin
        SRAM_ADDR = {word, 1'b1};
        state_n   = DONE;
      end
      WR_LO: begin
        SRAM_ADDR = {word, 1'b0};
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = val_Rm_in[15:0];
        state_n   = WR_HI;
      end
      WR_HI: begin
        SRAM_ADDR = {word, 1'b1};
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = val_Rm_in[31:16];
        state_n   = DONE;
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a behavioural SRAM on the shared data bus.
module tb_mem_stage_sram;

  logic        clk;
  logic        rst;
  logic        wb_en_in, mem_read_in, mem_write_in;
  logic [31:0] alu_out_in, val_rm_in;
  logic [3:0]  dst_in;
  logic        wb_en_out, mem_read_out;
  logic [3:0]  dst_out;
  logic [31:0] alu_out_out, mem_data_out;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n;

  logic [15:0] mem [0:262143];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          snap;

  mem_stage_sram dut (
    .clk          (clk),
    .rst          (rst),
    .WB_en_in     (wb_en_in),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .alu_out_in   (alu_out_in),
    .val_Rm_in    (val_rm_in),
    .dst_in       (dst_in),
    .WB_en_out    (wb_en_out),
    .mem_read_out (mem_read_out),
    .dst_out      (dst_out),
    .alu_out_out  (alu_out_out),
    .mem_data_out (mem_data_out),
    .ready        (ready),
    .SRAM_ADDR    (sram_addr),
    .SRAM_DQ      (sram_dq),
    .SRAM_WE_N    (sram_we_n)
  );

  // SRAM outputs its contents whenever not being written
  assign sram_dq = sram_we_n ? mem[sram_addr] : 'z;

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr] <= sram_dq;
      strobes <= strobes + 1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = '0;
    rst = 1'b1;
    wb_en_in = 0; mem_read_in = 0; mem_write_in = 0;
    alu_out_in = '0; val_rm_in = '0; dst_in = '0;
    #2;
    check("rst_data",  mem_data_out, 32'h0);
    check("rst_we_n",  {31'b0, sram_we_n}, 32'h1);
    check("rst_addr",  {14'b0, sram_addr}, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'h1);
    #10 rst = 1'b0;

    // non-memory op
    wb_en_in = 1; alu_out_in = 32'h12345678; dst_in = 4'd3;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("nm_ready", {31'b0, ready}, 32'h1);
      check("nm_wb",    {31'b0, wb_en_out}, 32'h1);
      check("nm_dst",   {28'b0, dst_out}, 32'h3);
      check("nm_alu",   alu_out_out, 32'h12345678);
      check("nm_we_n",  {31'b0, sram_we_n}, 32'h1);
      check("nm_addr",  {14'b0, sram_addr}, 32'h0);
      step();
    end

    // store 0xDEADBEEF at 1024+8
    wb_en_in = 0; mem_write_in = 1; alu_out_in = 32'd1032; val_rm_in = 32'hDEADBEEF;
    #1;
    check("st_c0_ready", {31'b0, ready}, 32'h0);
    step();
    check("st_lo_addr",  {14'b0, sram_addr}, 32'h4);
    check("st_lo_dq",    {16'b0, sram_dq}, 32'hBEEF);
    check("st_lo_we_n",  {31'b0, sram_we_n}, 32'h0);
    check("st_c1_ready", {31'b0, ready}, 32'h0);
    step();
    check("st_hi_addr",  {14'b0, sram_addr}, 32'h5);
    check("st_hi_dq",    {16'b0, sram_dq}, 32'hDEAD);
    check("st_hi_we_n",  {31'b0, sram_we_n}, 32'h0);
    check("st_c2_ready", {31'b0, ready}, 32'h0);
    step();
    check("st_c3_ready", {31'b0, ready}, 32'h1);
    check("st_done_we_n", {31'b0, sram_we_n}, 32'h1);
    check("st_done_addr", {14'b0, sram_addr}, 32'h0);
    mem_write_in = 0;
    step();
    check("st_mem4", {16'b0, mem[4]}, 32'hBEEF);
    check("st_mem5", {16'b0, mem[5]}, 32'hDEAD);

    // load the same word back; val_Rm differs so a stray DUT drive corrupts the bus
    mem_read_in = 1; alu_out_in = 32'd1032; val_rm_in = 32'h12345678;
    #1;
    check("ld_c0_ready", {31'b0, ready}, 32'h0);
    check("ld_rd_pass",  {31'b0, mem_read_out}, 32'h1);
    step();
    check("ld_lo_addr",  {14'b0, sram_addr}, 32'h4);
    check("ld_lo_we_n",  {31'b0, sram_we_n}, 32'h1);
    check("ld_lo_dq",    {16'b0, sram_dq}, 32'hBEEF);
    check("ld_c1_ready", {31'b0, ready}, 32'h0);
    step();
    check("ld_hi_addr",  {14'b0, sram_addr}, 32'h5);
    check("ld_hi_dq",    {16'b0, sram_dq}, 32'hDEAD);
    check("ld_half",     mem_data_out, 32'h0000BEEF);
    check("ld_c2_ready", {31'b0, ready}, 32'h0);
    step();
    check("ld_c3_ready", {31'b0, ready}, 32'h1);
    check("ld_data",     mem_data_out, 32'hDEADBEEF);
    step();
    check("ld_c4_ready", {31'b0, ready}, 32'h0);
    check("ld_c4_addr",  {14'b0, sram_addr}, 32'h0);
    check("ld_c4_we_n",  {31'b0, sram_we_n}, 32'h1);
    mem_read_in = 0;
    #1;
    check("ld_idle_ready", {31'b0, ready}, 32'h1);
    step();
    check("ld_hold", mem_data_out, 32'hDEADBEEF);
    check("ld_idle_addr", {14'b0, sram_addr}, 32'h0);

    // simultaneous request: write wins
    mem_read_in = 1; mem_write_in = 1; alu_out_in = 32'd1024 + 32'h80; val_rm_in = 32'h11112222;
    step();
    check("sim_lo_addr", {14'b0, sram_addr}, 32'h40);
    check("sim_lo_we_n", {31'b0, sram_we_n}, 32'h0);
    check("sim_lo_dq",   {16'b0, sram_dq}, 32'h2222);
    step();
    check("sim_hi_addr", {14'b0, sram_addr}, 32'h41);
    check("sim_hi_dq",   {16'b0, sram_dq}, 32'h1111);
    step();
    check("sim_ready",   {31'b0, ready}, 32'h1);
    check("sim_data",    mem_data_out, 32'hDEADBEEF);
    mem_read_in = 0; mem_write_in = 0;
    step();

    // address wrap below the 1024 base
    mem_write_in = 1; alu_out_in = 32'd1020; val_rm_in = 32'hA5A55A5A;
    step();
    check("wrap_lo_addr", {14'b0, sram_addr}, 32'h3FFFE);
    check("wrap_lo_we_n", {31'b0, sram_we_n}, 32'h0);
    step();
    check("wrap_hi_addr", {14'b0, sram_addr}, 32'h3FFFF);
    step();
    check("wrap_ready",   {31'b0, ready}, 32'h1);
    mem_write_in = 0;
    step();

    // reset pulsed during WR_LO, request held throughout
    mem_write_in = 1; alu_out_in = 32'd1024 + 32'd16; val_rm_in = 32'hCAFEF00D;
    snap = strobes;
    step();
    check("rw_lo_we_n", {31'b0, sram_we_n}, 32'h0);
    rst = 1'b1;
    #1;
    check("rw_abort_we_n",  {31'b0, sram_we_n}, 32'h1);
    check("rw_abort_addr",  {14'b0, sram_addr}, 32'h0);
    check("rw_abort_ready", {31'b0, ready}, 32'h0);
    check("rw_abort_data",  mem_data_out, 32'h0);
    step();
    rst = 1'b0;
    check("rw_no_strobe", strobes, snap);
    check("rw_mem9_kept", {16'b0, mem[9]}, 32'h0);
    check("rw_c0_ready",  {31'b0, ready}, 32'h0);
    step();
    check("rw_c1_addr",  {14'b0, sram_addr}, 32'h8);
    check("rw_c1_ready", {31'b0, ready}, 32'h0);
    step();
    check("rw_c2_addr",  {14'b0, sram_addr}, 32'h9);
    check("rw_c2_ready", {31'b0, ready}, 32'h0);
    step();
    check("rw_c3_ready", {31'b0, ready}, 32'h1);
    mem_write_in = 0;
    step();
    check("rw_mem8",    {16'b0, mem[8]}, 32'hF00D);
    check("rw_mem9",    {16'b0, mem[9]}, 32'hCAFE);
    check("rw_strobes", strobes, snap + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset; clk is the clock and rst is the reset.
REQ-002 clk  input  1  stage clock, all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 WB_en_in, mem_read_in, mem_write_in  input  1 each  control bits from the execute stage.
REQ-005 alu_out_in  input  32  byte address for loads and stores; result for non-memory ops.
REQ-006 val_Rm_in  input  32  store data.
REQ-007 dst_in  input  4  destination register index.
REQ-008 WB_en_out, mem_read_out  output  1 each  combinational pass-through of the inputs.
REQ-009 dst_out  output  4  combinational pass-through of dst_in.
REQ-010 alu_out_out  output  32  combinational pass-through of alu_out_in.
REQ-011 mem_data_out  output  32  registered load result.
REQ-012 ready  output  1  0 means freeze the pipeline; 1 means the stage completes this cycle.
REQ-013 SRAM_ADDR  output  18  halfword address to the external SRAM.
REQ-014 SRAM_DQ  inout  16  SRAM data bus.
REQ-015 SRAM_WE_N  output  1  active-low SRAM write enable.

Function
REQ-016 Offset computation:
- offs = alu_out_in - 1024, modulo 2^32.
- Low halfword address = {offs[18:2],1'b0}; high halfword address = {offs[18:2],1'b1}.
- offs[1:0] is ignored.
REQ-017 FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-018 IDLE transitions:
- mem_write_in=1 -> WR_LO.
- Else mem_read_in=1 -> RD_LO.
- Else stay in IDLE.
- A write takes priority when both request bits are 1.
REQ-019 Read sequence:
- RD_LO: drive the low address; capture SRAM_DQ into mem_data_out[15:0] at the clock edge; go to RD_HI.
- RD_HI: drive the high address; capture SRAM_DQ into mem_data_out[31:16]; go to DONE.
REQ-020 Write sequence:
- WR_LO: drive the low address, SRAM_DQ=val_Rm_in[15:0], SRAM_WE_N=0; go to WR_HI.
- WR_HI: drive the high address, SRAM_DQ=val_Rm_in[31:16], SRAM_WE_N=0; go to DONE.
REQ-021 DONE -> IDLE unconditionally.
REQ-022 ready = 1 in DONE, or in IDLE with no memory request; ready = 0 otherwise (combinational).
REQ-023 Latency: a request first seen in IDLE at cycle 0 produces ready=0 in cycles 0-2 and ready=1 in cycle 3; mem_data_out is valid from cycle 3 until the next load overwrites it.
REQ-024 Non-memory ops (both request bits 0) complete with ready=1 in the same cycle, with no SRAM activity.
REQ-025 SRAM_DQ SHALL be high-Z in every state except WR_LO and WR_HI; SRAM_WE_N=1 outside those states.
REQ-026 SRAM_ADDR = 0 in IDLE and DONE.
REQ-027 Inputs are held stable by the upstream freeze while ready=0; the block does not latch them.
REQ-028 A request present in the DONE cycle is not restarted; a new access starts only from IDLE on the following cycle.

Reset
REQ-029 rst SHALL asynchronously force:
- state=IDLE, mem_data_out=0, SRAM_WE_N=1, SRAM_DQ=high-Z, SRAM_ADDR=0.
- ready=1 when no request is present.
REQ-030 Reset asserted mid-access SHALL abort the access with no further SRAM write strobe; after release the FSM restarts from IDLE, and a held request begins a fresh 4-cycle access.

Verification
REQ-031 Store:
- Stimulus: alu_out_in=1024+8, val_Rm_in=0xDEADBEEF, mem_write_in=1.
- Response: WR_LO addr=4, DQ=0xBEEF, WE_N=0; WR_HI addr=5, DQ=0xDEAD, WE_N=0; ready pattern 0,0,0,1.
REQ-032 Load:
- Stimulus: same address; SRAM model returns 0xBEEF at 4 and 0xDEAD at 5.
- Response: mem_data_out=0xDEADBEEF in cycle 3, ready=1 in cycle 3 only; SRAM_DQ never driven by the block.
REQ-033 Non-memory op:
- Stimulus: mem_read_in=mem_write_in=0, alu_out_in=0x12345678, dst_in=3, WB_en_in=1.
- Response: ready=1 every cycle; pass-throughs match inputs; SRAM_WE_N=1.
REQ-034 Simultaneous request:
- Stimulus: mem_read_in=mem_write_in=1.
- Response: write path taken (WR_LO, WR_HI); mem_data_out unchanged.
REQ-035 Reset during WR_LO:
- Stimulus: rst pulsed during WR_LO.
- Response: SRAM_WE_N=1 and DQ=high-Z immediately; no WR_HI strobe; a held request then takes 4 cycles from release.
REQ-036 Address wrap:
- Stimulus: alu_out_in=1020 (offs=0xFFFFFFFC).
- Response: SRAM_ADDR=0x3FFFE then 0x3FFFF.
